// File: rtl/bounding_box_pkg.sv
// Shared sizes and FSM encoding for the bounding-box scanner.
package bounding_box_pkg;

    localparam int IMG_W   = 100;
    localparam int IMG_H   = 100;
    localparam int COORD_W = 7;
    localparam int ADDR_W  = 14;

    // Reset value of the min registers: larger than any legal coordinate.
    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/bounding_box_accum.sv
// Min/max accumulator for the coordinates of foreground pixels.
module bbox_accum
    import bounding_box_pkg::*;
(
    input  logic               clk_i,
    input  logic               clear_i,
    input  logic               valid_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [COORD_W-1:0] x_min_o,
    output logic [COORD_W-1:0] y_min_o,
    output logic [COORD_W-1:0] x_max_o,
    output logic [COORD_W-1:0] y_max_o
);

    logic [COORD_W-1:0] x_min_q, y_min_q, x_max_q, y_max_q;
    logic [COORD_W-1:0] x_min_d, y_min_d, x_max_d, y_max_d;

    // Next bounds: all four extend together when a foreground pixel arrives.
    always_comb begin
        x_min_d = x_min_q;
        y_min_d = y_min_q;
        x_max_d = x_max_q;
        y_max_d = y_max_q;
        if (valid_i) begin
            if (x_i < x_min_q) x_min_d = x_i;
            if (y_i < y_min_q) y_min_d = y_i;
            if (x_i > x_max_q) x_max_d = x_i;
            if (y_i > y_max_q) y_max_d = y_i;
        end
    end

    // Bound registers; clear restores the empty-box values (min=max code, max=0).
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            x_min_q <= COORD_MAX;
            y_min_q <= COORD_MAX;
            x_max_q <= '0;
            y_max_q <= '0;
        end else begin
            x_min_q <= x_min_d;
            y_min_q <= y_min_d;
            x_max_q <= x_max_d;
            y_max_q <= y_max_d;
        end
    end

    assign x_min_o = x_min_q;
    assign y_min_o = y_min_q;
    assign x_max_o = x_max_q;
    assign y_max_o = y_max_q;

endmodule

// File: rtl/bounding_box_top.sv
// Scans a preloaded image ROM in raster order and reports the bounding box
// of all nonzero pixels. KEY[3] (active-low pushbutton) is the reset.
module bounding_box_top #(
    parameter int IMG_W = bounding_box_pkg::IMG_W,
    parameter int IMG_H = bounding_box_pkg::IMG_H
) (
    input logic       CLOCK_50,
    input logic [3:0] KEY
);
    import bounding_box_pkg::*;

    localparam int                 NPIX      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(IMG_W - 1);

    // Image store: no write port, filled externally.
    logic [7:0] ram [0:NPIX-1];

    logic rst;
    logic unused_keys;
    assign rst         = ~KEY[3];
    assign unused_keys = ^KEY[2:0];

    state_e             state_q;
    logic               done;
    logic [ADDR_W-1:0]  addr_q;
    logic [COORD_W-1:0] x_q, y_q;

    logic [7:0]         rdata_q;
    logic               pix_vld_q;
    logic [COORD_W-1:0] px_q, py_q;

    logic [COORD_W-1:0] xMin, yMin, xMax, yMax;

    // Scan FSM: one address per cycle in SCAN, one DRAIN cycle for the last
    // read to land, then DONE holds until reset.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q <= IDLE;
            done    <= 1'b0;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE:  state_q <= SCAN;
                SCAN: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        if (x_q == X_LAST) begin
                            x_q <= '0;
                            y_q <= y_q + 1'b1;
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                    done    <= 1'b1;
                end
                DONE:  ;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Synchronous ROM read, one cycle of latency.
    always_ff @(posedge CLOCK_50) begin
        rdata_q <= ram[addr_q];
    end

    // Coordinates and valid travel alongside the read so they line up with rdata_q.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            pix_vld_q <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
        end else begin
            pix_vld_q <= (state_q == SCAN);
            px_q      <= x_q;
            py_q      <= y_q;
        end
    end

    bbox_accum u_accum (
        .clk_i   (CLOCK_50),
        .clear_i (rst),
        .valid_i (pix_vld_q && (rdata_q != 8'd0)),
        .x_i     (px_q),
        .y_i     (py_q),
        .x_min_o (xMin),
        .y_min_o (yMin),
        .x_max_o (xMax),
        .y_max_o (yMax)
    );

endmodule

// File: tb/tb_bounding_box_top.sv
module tb_bounding_box_top;

    localparam int W    = 100;
    localparam int H    = 100;
    localparam int NPIX = W * H;

    typedef struct {
        string name;
        int    xmin, ymin, xmax, ymax;
    } exp_t;

    logic       CLOCK_50 = 1'b0;
    logic [3:0] KEY      = 4'h0;

    int   tests = 0;
    int   fails = 0;
    int   cnt   = 0;
    exp_t sb_q[$];
    logic [7:0] img [NPIX];

    bounding_box_top #(.IMG_W(W), .IMG_H(H)) dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Cycles since the last edge that saw reset released.
    always @(posedge CLOCK_50) begin
        if (!KEY[3]) cnt <= 0;
        else         cnt <= cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: bounding box of nonzero pixels straight from the image array.
    function automatic exp_t model(input string name);
        exp_t r;
        r.name = name;
        r.xmin = 127; r.ymin = 127; r.xmax = 0; r.ymax = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (img[y*W + x] != 8'd0) begin
                    if (x < r.xmin) r.xmin = x;
                    if (x > r.xmax) r.xmax = x;
                    if (y < r.ymin) r.ymin = y;
                    if (y > r.ymax) r.ymax = y;
                end
        return r;
    endfunction

    task automatic clear_img();
        for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
    endtask

    task automatic set_px(input int x, input int y, input int v);
        img[y*W + x] = 8'(v);
    endtask

    task automatic fill_rect(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                set_px(x, y, $urandom_range(1, 255));
    endtask

    task automatic load_ram();
        for (int i = 0; i < NPIX; i++) dut.ram[i] = img[i];
    endtask

    task automatic set_key(input logic k3);
        KEY = {k3, 3'($urandom)};
    endtask

    task automatic check_reset_state(input string name);
        check({name, " rst done"}, int'(dut.done), 0);
        check({name, " rst xMin"}, int'(dut.xMin), 127);
        check({name, " rst yMin"}, int'(dut.yMin), 127);
        check({name, " rst xMax"}, int'(dut.xMax), 0);
        check({name, " rst yMax"}, int'(dut.yMax), 0);
    endtask

    // Monitor: on each rising done, pop the expected result and compare.
    initial begin
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge CLOCK_50);
            if (dut.done && !prev) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: done rose at cycle %0d with nothing expected", cnt);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, " done_cycle"}, cnt, NPIX + 2);
                    check({e.name, " xMin"}, int'(dut.xMin), e.xmin);
                    check({e.name, " yMin"}, int'(dut.yMin), e.ymin);
                    check({e.name, " xMax"}, int'(dut.xMax), e.xmax);
                    check({e.name, " yMax"}, int'(dut.yMax), e.ymax);
                end
            end
            prev = dut.done;
        end
    end

    // One scan of the current img; optionally abort with a reset at cycle 5000.
    task automatic run(input string name, input bit abort_mid);
        exp_t e;
        bit   got;
        @(negedge CLOCK_50);
        set_key(1'b0);
        load_ram();
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_reset_state(name);
        e = model(name);
        sb_q.push_back(e);
        set_key(1'b1);
        if (abort_mid) begin
            repeat (5000) @(negedge CLOCK_50);
            check({name, " mid done"}, int'(dut.done), 0);
            set_key(1'b0);
            repeat (2) @(negedge CLOCK_50);
            check_reset_state({name, " mid"});
            set_key(1'b1);
        end
        got = 1'b0;
        for (int i = 0; i < NPIX + 100 && !got; i++) begin
            @(negedge CLOCK_50);
            if (sb_q.size() == 0) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: done not seen, expected at cycle %0d", name, NPIX + 2);
            sb_q.delete();
        end
        // DONE must be absorbing with stable bounds.
        repeat (5) @(negedge CLOCK_50);
        check({name, " hold done"}, int'(dut.done), 1);
        check({name, " hold xMin"}, int'(dut.xMin), e.xmin);
        check({name, " hold yMax"}, int'(dut.yMax), e.ymax);
    endtask

    initial begin
        int n, lim;
        clear_img();
        fill_rect(28, 79, 29, 65);
        run("rect", 1'b0);

        clear_img();
        for (int y = 34; y <= 78; y++) begin
            lim = 28 + ((y - 34) * (69 - 28)) / (78 - 34);
            for (int x = 28; x <= lim; x++) set_px(x, y, $urandom_range(1, 255));
        end
        run("tri", 1'b0);

        clear_img();
        set_px(99, 99, $urandom_range(1, 255));
        run("px99", 1'b0);

        clear_img();
        set_px(0, 0, $urandom_range(1, 255));
        run("px00", 1'b0);

        clear_img();
        run("zero", 1'b0);

        clear_img();
        fill_rect(28, 79, 29, 65);
        run("abort", 1'b1);

        clear_img();
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++)
            set_px($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(1, 255));
        run("rand", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bounding_box_top.md
BOUNDING_BOX_TOP -- requirements
Module: bounding_box_top

Interface
REQ-001 The block SHALL use one clock and one reset; the reset is synchronous and active-high.
REQ-002 Parameter IMG_W, default 100, SHALL set the image width in pixels.
REQ-003 Parameter IMG_H, default 100, SHALL set the image height in pixels.
REQ-004 Port CLOCK_50, input, 1 bit, SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-005 Port KEY, input, 4 bits, SHALL carry the board pushbuttons, which are low when pressed.
REQ-006 The internal reset rst SHALL be derived as rst = NOT KEY[3] and sampled synchronously; it SHALL be active-high.
REQ-007 KEY[2:0] SHALL be ignored.
REQ-008 Internal signal done, 1 bit, SHALL be hierarchically visible and high when the scan is complete.
REQ-009 Internal registers xMin, yMin, xMax, yMax, 7 bits unsigned each, SHALL be hierarchically visible.
REQ-010 Internal array ram, IMG_W*IMG_H words of 8 bits, SHALL be hierarchically visible and loadable by $readmemh.
REQ-011 The block SHALL have no other ports.

Function
REQ-012 Pixel (x,y) SHALL be stored at ram address y*IMG_W + x, row-major, with x as column and y as row, both 0-based.
REQ-013 A pixel SHALL be foreground when its word is nonzero.
REQ-014 ram SHALL have no write port; its contents SHALL change only by external load.
REQ-015 ram SHALL be read synchronously with 1-cycle latency.
REQ-016 The FSM SHALL have states IDLE, SCAN, DRAIN and DONE.
REQ-017 While rst is high, the FSM SHALL enter IDLE.
REQ-018 In the first cycle with rst low, the FSM SHALL move from IDLE to SCAN.
REQ-019 In SCAN, the read address SHALL start at 0 and increment by 1 every cycle, with x and y counters tracked alongside it.
REQ-020 The x counter SHALL wrap at IMG_W-1 to 0 and increment y at the same time.
REQ-021 After the address IMG_W*IMG_H-1 is issued, the FSM SHALL move to DRAIN.
REQ-022 DRAIN SHALL last exactly 1 cycle, consuming the last read data, and then move to DONE.
REQ-023 The read data and the coordinates of the pixel being read SHALL be pipelined together, aligned to the 1-cycle read latency.
REQ-024 For each valid foreground pixel, the block SHALL apply: xMin = min(xMin, x), xMax = max(xMax, x), yMin = min(yMin, y), yMax = max(yMax, y).
REQ-025 All four updates in REQ-024 SHALL take effect in the same cycle.
REQ-026 DONE SHALL be absorbing until rst is asserted.
REQ-027 done SHALL be high only in DONE.
REQ-028 done SHALL rise exactly IMG_W*IMG_H+2 cycles after the first cycle with rst low (10002 cycles at default size).
REQ-029 When the image has no foreground pixel, the result SHALL be xMin = yMin = 127, xMax = yMax = 0, with done still asserted.
REQ-030 A single foreground pixel SHALL give xMin = xMax and yMin = yMax.
REQ-031 In DONE, xMin, yMin, xMax and yMax SHALL hold stable.
REQ-032 An rst assertion mid-scan SHALL abort the scan, clear the results and restart the scan from address 0 after release.
REQ-033 Changing ram contents mid-scan SHALL produce undefined results but SHALL NOT hang the FSM.

Reset
REQ-034 On rst, the block SHALL set: state = IDLE, done = 0, address = x = y = 0.
REQ-035 On rst, the block SHALL set: xMin = yMin = 127, xMax = yMax = 0.
REQ-036 On rst, the pipeline valid flag SHALL be cleared.
REQ-037 ram contents SHALL be unaffected by rst.

Structure
REQ-038 Package bounding_box_pkg SHALL hold IMG_W, IMG_H, COORD_W = 7, ADDR_W = 14 and the FSM state enum.
REQ-039 Sub-module bbox_accum SHALL hold the four min/max registers, with inputs clear, valid, x and y.
REQ-040 ram, the counters and the FSM SHALL remain in the top module.

Verification
REQ-041 Filled rectangle spanning x 28..79, y 29..65 -> done, with xMin 28, yMin 29, xMax 79, yMax 65.
REQ-042 Triangle with extreme pixels at x 28 and 69, y 34 and 78 -> (28, 34, 69, 78).
REQ-043 Single pixel at (99,99) -> (99, 99, 99, 99).
REQ-044 Single pixel at (0,0) -> (0, 0, 0, 0).
REQ-045 All-zero image -> (127, 127, 0, 0), with done high at cycle 10002.
REQ-046 Rectangle image, rst pulsed at cycle 5000, then rst released -> done low through the restart and correct bounds after 10002 further cycles.
REQ-047 Back-to-back reloads of ram with reset pulses in between -> each run reports only the current image's bounds, with no carry-over.
